// File: rtl/corescore_pkg.sv
// Shared definitions for the corescore stream arbiter: state encoding and default sizing.
package corescore_pkg;

    localparam int CORESCORE_NUM_SRC = 4;
    localparam int CORESCORE_DW      = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/corescore_rr_pick.sv
// Combinational round-robin picker: first requester at or above i_ptr, wrapping modulo NUM_SRC.
module corescore_rr_pick
    import corescore_pkg::*;
#(
    parameter int NUM_SRC = CORESCORE_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]         i_req,
    input  logic [$clog2(NUM_SRC)-1:0] i_ptr,
    output logic [NUM_SRC-1:0]         o_grant,
    output logic [$clog2(NUM_SRC)-1:0] o_idx,
    output logic                       o_any
);

    localparam int IW = $clog2(NUM_SRC);

    // One extra bit so ptr+offset never overflows before the modulo fold.
    logic [IW:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            w_cand = {1'b0, i_ptr} + (IW+1)'(off);
            if (w_cand >= (IW+1)'(NUM_SRC)) begin
                w_cand = w_cand - (IW+1)'(NUM_SRC);
            end
            if (!o_any && i_req[w_cand[IW-1:0]]) begin
                o_any                   = 1'b1;
                o_idx                   = w_cand[IW-1:0];
                o_grant[w_cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC AXI-Stream sources onto one emitter.
module corescore_stream_arbiter
    import corescore_pkg::*;
#(
    parameter int NUM_SRC = CORESCORE_NUM_SRC,
    parameter int DW      = CORESCORE_DW
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_SRC*DW-1:0] i_tdata,
    input  logic [NUM_SRC-1:0]    i_tlast,
    input  logic [NUM_SRC-1:0]    i_tvalid,
    output logic [NUM_SRC-1:0]    o_tready,
    input  logic [NUM_SRC-1:0]    i_src_en,
    output logic [DW-1:0]         o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic [NUM_SRC-1:0]    o_grant,
    output logic                  o_busy
);

    localparam int IW = $clog2(NUM_SRC);

    arb_state_e          r_state, w_state_next;
    logic [NUM_SRC-1:0]  r_grant, w_grant_next;
    logic [IW-1:0]       r_owner, w_owner_next;
    logic [IW-1:0]       r_ptr, w_ptr_next;

    logic [NUM_SRC-1:0]  w_req;
    logic [NUM_SRC-1:0]  w_pick_grant;
    logic [IW-1:0]       w_pick_idx;
    logic                w_pick_any;
    logic                w_last_acc;
    logic [DW-1:0]       w_dsel [NUM_SRC];

    assign w_req      = i_tvalid & i_src_en;
    assign w_last_acc = i_tvalid[r_owner] & i_tlast[r_owner] & i_tready;

    corescore_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Ownership only ends on an accepted last beat; valid or enable dropping never releases it.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_next = ST_LOCKED;
                    w_grant_next = w_pick_grant;
                    w_owner_next = w_pick_idx;
                end
            end
            ST_LOCKED: begin
                if (w_last_acc) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                    w_ptr_next   = (r_owner == IW'(NUM_SRC-1)) ? '0 : r_owner + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_dsel
            assign w_dsel[gi] = i_tdata[gi*DW +: DW] & {DW{r_grant[gi]}};
        end
    endgenerate

    always_comb begin
        o_tdata  = '0;
        o_tlast  = 1'b0;
        o_tvalid = 1'b0;
        o_tready = '0;
        if (r_state == ST_LOCKED) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                o_tdata = o_tdata | w_dsel[k];
            end
            o_tlast  = |(i_tlast & r_grant);
            o_tvalid = |(i_tvalid & r_grant);
            o_tready = r_grant & {NUM_SRC{i_tready}};
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Bench for corescore_stream_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_corescore_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] tdata;
    logic [N-1:0]    tlast, tvalid, src_en, o_tready, o_grant;
    logic            tready, o_tlast, o_tvalid, o_busy;
    logic [DW-1:0]   o_tdata;

    always #5 clk = ~clk;

    corescore_stream_arbiter #(.NUM_SRC(N), .DW(DW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_tdata  (tdata),
        .i_tlast  (tlast),
        .i_tvalid (tvalid),
        .o_tready (o_tready),
        .i_src_en (src_en),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (tready),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    // Model: owner index (-1 when nobody owns the emitter) and next search start.
    int m_owner = -1;
    int m_ptr   = 0;

    logic [7:0] s1_bytes [3]  = '{8'h41, 8'h42, 8'h43};
    logic [3:0] s2_exp   [15] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                                  4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    logic [3:0] s3_v  [11] = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0110,
                               4'b0110, 4'b0100, 4'b0100, 4'b0101, 4'b0101};
    logic [3:0] s3_l  [11] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0110,
                               4'b0110, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] s3_en [11] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hF,
                               4'hF, 4'hF, 4'hF, 4'hB, 4'hB};
    logic       s3_tr [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] s3_g  [11] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2,
                               4'h2, 4'h0, 4'h4, 4'h0, 4'h1};

    logic [N-1:0] beat, acc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (req[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
        end else if (m_owner < 0) begin
            if (pick(tvalid & src_en, m_ptr) >= 0) m_owner <= pick(tvalid & src_en, m_ptr);
        end else if (tvalid[m_owner] && tlast[m_owner] && tready) begin
            m_ptr   <= (m_owner + 1) % N;
            m_owner <= -1;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg, etr;
        logic         ev;
        if (cmp_en) begin
            eg  = '0;
            etr = '0;
            ev  = 1'b0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                ev          = tvalid[m_owner];
                if (tready) etr[m_owner] = 1'b1;
            end
            chk("grant", o_grant, eg);
            chk("busy", o_busy, m_owner >= 0);
            chk("tvalid", o_tvalid, ev);
            chk("tready", o_tready, etr);
            if (ev) begin
                chk("tdata", o_tdata, tdata[m_owner*DW +: DW]);
                chk("tlast", o_tlast, tlast[m_owner]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tvalid = '0;
        tlast  = '0;
        rst_n  = 1'b0;
        cyc();
        cyc();
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        tdata  = '0;
        tlast  = '0;
        tvalid = '0;
        src_en = '1;
        tready = 1'b0;
        #2;
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tready", o_tready, 0);
        cmp_en = 1;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Three-byte packet from source 0
        tready      = 1'b1;
        tvalid      = 4'b0001;
        tdata[7:0]  = s1_bytes[0];
        @(negedge clk);
        chk("s1_latency_tvalid", o_tvalid, 0);
        chk("s1_idle_grant", o_grant, 0);
        cyc();
        for (int b = 0; b < 3; b++) begin
            tdata[7:0] = s1_bytes[b];
            tlast[0]   = (b == 2);
            @(negedge clk);
            chk("s1_tdata", o_tdata, s1_bytes[b]);
            chk("s1_grant", o_grant, 4'b0001);
            chk("s1_tlast", o_tlast, (b == 2));
            cyc();
        end
        tvalid = '0;
        tlast  = '0;
        @(negedge clk);
        chk("s1_idle_after_busy", o_busy, 0);
        chk("s1_idle_after_grant", o_grant, 0);
        cyc();

        // All sources streaming two-beat packets
        do_reset();
        src_en = '1;
        tready = 1'b1;
        tvalid = '1;
        beat   = '0;
        for (int c = 0; c < 15; c++) begin
            tlast = beat;
            for (int k = 0; k < N; k++) tdata[k*DW +: DW] = 8'(k*16 + int'(beat[k]));
            @(negedge clk);
            chk("s2_grant_order", o_grant, s2_exp[c]);
            acc = o_tready & tvalid;
            cyc();
            beat = beat ^ acc;
        end

        // Stalls and valid gaps keep source 1, then single-beat src2, then masked src2 at ptr=3
        do_reset();
        tdata = 32'hA5C3_7E19;
        for (int c = 0; c < 11; c++) begin
            tvalid = s3_v[c];
            tlast  = s3_l[c];
            src_en = s3_en[c];
            tready = s3_tr[c];
            @(negedge clk);
            chk("s3_grant", o_grant, s3_g[c]);
            cyc();
        end

        // Reset in the middle of a source 2 packet
        do_reset();
        src_en = '1;
        tready = 1'b1;
        tvalid = 4'b0100;
        tlast  = '0;
        @(negedge clk);
        chk("s5_idle_grant", o_grant, 0);
        cyc();
        @(negedge clk);
        chk("s5_beat1_grant", o_grant, 4'b0100);
        cyc();
        tdata[2*DW +: DW] = 8'h77;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_tvalid", o_tvalid, 0);
        chk("s5_rst_grant", o_grant, 0);
        chk("s5_rst_busy", o_busy, 0);
        chk("s5_rst_tready", o_tready, 0);
        cyc();
        rst_n  = 1'b1;
        tvalid = '1;
        @(negedge clk);
        chk("s5_post_idle", o_grant, 0);
        cyc();
        @(negedge clk);
        chk("s5_post_src0", o_grant, 4'b0001);
        cyc();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tvalid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                tlast[k]  = ($urandom_range(0, 2) == 0);
                src_en[k] = ($urandom_range(0, 3) != 0);
            end
            tready = ($urandom_range(0, 3) != 0);
            tdata  = (N*DW)'($urandom);
            rst_n  = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst_n = 1'b1;
        cyc();

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/corescore_stream_arbiter.md
CORESCORE_STREAM_ARBITER -- requirements
Module: corescore_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of AXI-Stream byte sources sharing one emitter (legal 2..16).
REQ-002 SHALL have parameter DW, default 8, stream data width in bits.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_tdata, input, NUM_SRC*DW, source data; source k occupies bits [k*DW +: DW].
REQ-006 SHALL have port i_tlast, input, NUM_SRC, per-source end-of-packet.
REQ-007 SHALL have port i_tvalid, input, NUM_SRC, per-source valid.
REQ-008 SHALL have port o_tready, output, NUM_SRC, per-source ready.
REQ-009 SHALL have port i_src_en, input, NUM_SRC, per-source arbitration enable mask.
REQ-010 SHALL have port o_tdata, output, DW, data to emitter.
REQ-011 SHALL have port o_tlast, output, 1, end-of-packet to emitter.
REQ-012 SHALL have port o_tvalid, output, 1, valid to emitter.
REQ-013 SHALL have port i_tready, input, 1, emitter ready.
REQ-014 SHALL have port o_grant, output, NUM_SRC, one-hot current owner, all-zero when idle.
REQ-015 SHALL have port o_busy, output, 1, high while a packet is owned.

Function
REQ-016 SHALL implement FSM with two states: IDLE (no owner) and LOCKED (one owner).
REQ-017 In IDLE, requesters SHALL be i_tvalid & i_src_en; with none, SHALL stay IDLE.
REQ-018 In IDLE with ≥1 requester, SHALL register grant to first requester at or after round-robin pointer ptr, searching upward modulo NUM_SRC, and enter LOCKED next cycle.
REQ-019 In LOCKED, o_tdata/o_tlast/o_tvalid SHALL combinationally equal the owner's inputs, and o_tready[owner] SHALL equal i_tready; all other o_tready bits SHALL be 0.
REQ-020 In IDLE, o_tvalid and all o_tready SHALL be 0; latency from requester valid to o_tvalid SHALL be exactly 1 cycle.
REQ-021 Grant SHALL change only on a cycle where owner's i_tvalid, i_tlast and i_tready are all 1 (last beat accepted); then SHALL return to IDLE and set ptr to (owner+1) mod NUM_SRC.
REQ-022 Owner deasserting i_tvalid mid-packet SHALL NOT release the grant.
REQ-023 Deasserting i_src_en[owner] mid-packet SHALL NOT release the grant; it only affects the next arbitration.
REQ-024 Single-beat packet (tlast on first beat) SHALL release after that one beat.
REQ-025 ptr = NUM_SRC-1 SHALL wrap search to source 0.
REQ-026 Back-to-back packets SHALL incur exactly one IDLE cycle between last beat and next owner's first o_tvalid.
REQ-027 o_busy SHALL be 1 exactly in LOCKED; o_grant SHALL be one-hot in LOCKED.

Reset
REQ-028 i_rst_n low SHALL asynchronously force IDLE, ptr=0, o_grant=0, o_busy=0, o_tvalid=0, o_tready=0.
REQ-029 Reset mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from source 0.
REQ-030 Reset deassertion SHALL be externally synchronized to i_clk; block SHALL NOT contain a reset synchronizer.

Structure
REQ-031 Shared package corescore_pkg SHALL hold the arbiter state enum and the default NUM_SRC/DW constants.
REQ-032 Combinational round-robin selector SHALL be sub-module corescore_rr_pick (inputs req, ptr; outputs one-hot grant, index, any).
REQ-033 Datapath mux SHALL be AND-OR on one-hot grant; no storage on data path.

Verification
REQ-034 Src0 sends 3-byte packet 0x41,0x42,0x43(tlast), i_tready=1 -> o_tdata sequence identical, o_grant=0001 throughout, IDLE after.
REQ-035 All four sources valid continuously, 2-beat packets -> grant order 0,1,2,3,0; one idle cycle between packets.
REQ-036 Src1 owner, i_tready toggles 1/0 and src1 drops tvalid 2 cycles mid-packet while src2 valid -> grant stays 0010 until tlast accepted.
REQ-037 ptr=3, only src0 and src2 valid, i_src_en=1011 -> src0 granted (src2 masked).
REQ-038 Assert i_rst_n=0 on beat 2 of src2 packet -> same-cycle o_tvalid=0, o_grant=0; after release with all valid, src0 granted first.
